// File: rtl/and_gate.sv
// Branch-decision gate: PCSrc = membranch & zero, plus a debug statistics side-block.
// Latency: PCSrc is zero-cycle combinational; statistics outputs lag inputs by one clk edge.
// Backpressure: none; stats counters saturate at all-ones and never stall or wrap.
module and_gate #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 membranch,
    input  logic                 zero,
    input  logic                 clr_stats,
    output logic                 PCSrc,
    output logic                 pcsrc_q,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt,
    output logic                 taken_seen
);

    // The branch decision itself: a plain AND, kept free of clk/rst so it
    // stays valid (and X-propagates per normal AND rules) even when those
    // are undriven.
    logic w_pcsrc;
    assign w_pcsrc = membranch & zero;
    assign PCSrc   = w_pcsrc;

    logic                 r_pcsrc_q;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_taken_cnt;
    logic                 r_taken_seen;

    // Saturation detect: a counter at all-ones must hold rather than wrap.
    logic w_branch_full;
    logic w_taken_full;
    assign w_branch_full = &r_branch_cnt;
    assign w_taken_full  = &r_taken_cnt;

    // Next-value selection for the counters; clear beats increment.
    logic [CNT_WIDTH-1:0] w_branch_nxt;
    logic [CNT_WIDTH-1:0] w_taken_nxt;
    logic                 w_seen_nxt;

    // Compute next statistics state; defaults hold current values.
    always_comb begin
        w_branch_nxt = r_branch_cnt;
        w_taken_nxt  = r_taken_cnt;
        w_seen_nxt   = r_taken_seen;
        if (clr_stats) begin
            w_branch_nxt = '0;
            w_taken_nxt  = '0;
            w_seen_nxt   = 1'b0;
        end else begin
            if (membranch && !w_branch_full) begin
                w_branch_nxt = r_branch_cnt + 1'b1;
            end
            if (w_pcsrc && !w_taken_full) begin
                w_taken_nxt = r_taken_cnt + 1'b1;
            end
            if (w_pcsrc) begin
                w_seen_nxt = 1'b1;
            end
        end
    end

    // Statistics registers; async reset clears everything, pcsrc_q loads even on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcsrc_q    <= 1'b0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
            r_taken_seen <= 1'b0;
        end else begin
            r_pcsrc_q    <= w_pcsrc;
            r_branch_cnt <= w_branch_nxt;
            r_taken_cnt  <= w_taken_nxt;
            r_taken_seen <= w_seen_nxt;
        end
    end

    assign pcsrc_q    = r_pcsrc_q;
    assign branch_cnt = r_branch_cnt;
    assign taken_cnt  = r_taken_cnt;
    assign taken_seen = r_taken_seen;

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: truth table, async reset, counting, saturation, clear.
// Two instances share inputs: default width and CNT_WIDTH=4 for the saturation case.
// Expected stats are pushed per driven cycle and popped after the following edge.
module tb_and_gate;

    logic        clk;
    logic        rst;
    logic        membranch;
    logic        zero;
    logic        clr_stats;
    logic        clk_run;

    logic        pcsrc_a, pcsrc_q_a, seen_a;
    logic [15:0] bcnt_a, tcnt_a;
    logic        pcsrc_b, pcsrc_q_b, seen_b;
    logic [3:0]  bcnt_b, tcnt_b;

    int total = 0;
    int bad   = 0;

    and_gate #(.CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .membranch(membranch), .zero(zero), .clr_stats(clr_stats),
        .PCSrc(pcsrc_a), .pcsrc_q(pcsrc_q_a), .branch_cnt(bcnt_a), .taken_cnt(tcnt_a),
        .taken_seen(seen_a)
    );

    and_gate #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .membranch(membranch), .zero(zero), .clr_stats(clr_stats),
        .PCSrc(pcsrc_b), .pcsrc_q(pcsrc_q_b), .branch_cnt(bcnt_b), .taken_cnt(tcnt_b),
        .taken_seen(seen_b)
    );

    // Clock only toggles once the combinational-only phase is over.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct {
        logic q;
        int   b16;
        int   t16;
        int   b4;
        int   t4;
        logic s;
    } exp_t;

    exp_t sb_q[$];

    // Reference statistics state.
    int   m_b16, m_t16, m_b4, m_t4;
    logic m_s, m_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_b16 = 0; m_t16 = 0; m_b4 = 0; m_t4 = 0; m_s = 1'b0; m_q = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input exp_t e);
        chk({tag, ".pcsrc_q"},    {31'b0, pcsrc_q_a}, {31'b0, e.q});
        chk({tag, ".branch_cnt"}, {16'b0, bcnt_a},    e.b16);
        chk({tag, ".taken_cnt"},  {16'b0, tcnt_a},    e.t16);
        chk({tag, ".taken_seen"}, {31'b0, seen_a},    {31'b0, e.s});
        chk({tag, ".w4.pcsrc_q"}, {31'b0, pcsrc_q_b}, {31'b0, e.q});
        chk({tag, ".w4.branch"},  {28'b0, bcnt_b},    e.b4);
        chk({tag, ".w4.taken"},   {28'b0, tcnt_b},    e.t4);
        chk({tag, ".w4.seen"},    {31'b0, seen_b},    {31'b0, e.s});
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input string tag, input logic mb, input logic z, input logic clr);
        logic pc;
        exp_t e;
        exp_t got;
        membranch = mb;
        zero      = z;
        clr_stats = clr;
        pc = mb & z;
        #1;
        chk({tag, ".PCSrc"}, {31'b0, pcsrc_a}, {31'b0, pc});
        if (clr) begin
            m_b16 = 0; m_t16 = 0; m_b4 = 0; m_t4 = 0; m_s = 1'b0;
        end else begin
            if (mb && m_b16 < 65535) m_b16++;
            if (pc && m_t16 < 65535) m_t16++;
            if (mb && m_b4 < 15)     m_b4++;
            if (pc && m_t4 < 15)     m_t4++;
            m_s = m_s | pc;
        end
        m_q = pc;
        e.q = m_q; e.b16 = m_b16; e.t16 = m_t16; e.b4 = m_b4; e.t4 = m_t4; e.s = m_s;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk_stats(tag, got);
    endtask

    initial begin
        exp_t z_e;
        logic [1:0] tt_in  [4];
        logic       tt_exp [4];
        tt_in[0] = 2'b00; tt_in[1] = 2'b10; tt_in[2] = 2'b01; tt_in[3] = 2'b11;
        tt_exp[0] = 1'b0; tt_exp[1] = 1'b0; tt_exp[2] = 1'b0; tt_exp[3] = 1'b1;

        clk       = 1'bx;
        rst       = 1'bx;
        clk_run   = 1'b0;
        clr_stats = 1'b0;

        // Combinational truth table with clk/rst undriven.
        for (int i = 0; i < 4; i++) begin
            membranch = tt_in[i][1];
            zero      = tt_in[i][0];
            #1;
            chk($sformatf("tt%0d", i), {31'b0, pcsrc_a}, {31'b0, tt_exp[i]});
        end

        // X handling.
        membranch = 1'b0; zero = 1'bx; #1;
        chk("x_0andX", {31'b0, pcsrc_a}, 32'd0);
        membranch = 1'b1; zero = 1'bx; #1;
        chk("x_1andX", {31'b0, pcsrc_a}, {31'b0, 1'bx});

        // Reset with clock stopped.
        membranch = 1'b1; zero = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        z_e.q = 0; z_e.b16 = 0; z_e.t16 = 0; z_e.b4 = 0; z_e.t4 = 0; z_e.s = 0;
        chk_stats("reset", z_e);
        chk("reset.PCSrc", {31'b0, pcsrc_a}, 32'd1);

        clk = 1'b0;
        clk_run = 1'b1;
        @(posedge clk); #1;
        chk_stats("reset_hold", z_e);
        #4 rst = 1'b0;

        // Ten branch cycles, zero set on four of them.
        for (int i = 0; i < 10; i++) begin
            step($sformatf("cnt%0d", i), 1'b1, (i == 0 || i == 3 || i == 5 || i == 9), 1'b0);
        end
        chk("cnt.branch_total", {16'b0, bcnt_a}, 32'd10);
        chk("cnt.taken_total",  {16'b0, tcnt_a}, 32'd4);
        chk("cnt.seen",         {31'b0, seen_a}, 32'd1);

        // Asynchronous reset between edges with nonzero counters.
        step("pre_rst", 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_stats("async_rst", z_e);
        chk("async_rst.PCSrc", {31'b0, pcsrc_a}, 32'd0);
        zero = 1'b1; #0.5;
        chk("async_rst.PCSrc_follow", {31'b0, pcsrc_a}, 32'd1);
        #0.5 rst = 1'b0;

        // Saturation: the 4-bit instance must stick at 15.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0);
        end
        chk("sat.w4_branch", {28'b0, bcnt_b}, 32'd15);
        chk("sat.w4_taken",  {28'b0, tcnt_b}, 32'd15);
        chk("sat.w16_branch", {16'b0, bcnt_a}, 32'd20);

        // Clear pulse while taken branches keep arriving.
        step("clr", 1'b1, 1'b1, 1'b1);
        chk("clr.branch_zero", {16'b0, bcnt_a}, 32'd0);
        chk("clr.seen_zero",   {31'b0, seen_a}, 32'd0);
        step("after_clr", 1'b1, 1'b1, 1'b0);
        chk("after_clr.branch_one", {16'b0, bcnt_a}, 32'd1);
        chk("after_clr.seen_one",   {31'b0, seen_a}, 32'd1);

        // Mixed patterns after clear.
        step("mix0", 1'b0, 1'b1, 1'b0);
        step("mix1", 1'b1, 1'b0, 1'b0);
        step("mix2", 1'b0, 1'b0, 1'b0);
        step("mix3", 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/and_gate.md
# and_gate

Branch-decision gate for the MIPS-style datapath's MEM stage. Combinationally drives `PCSrc = membranch & zero`, which selects the branch target at the PC mux. A small clocked statistics side-block, off the `PCSrc` path, counts branch instructions and taken branches for debug. The side-block never affects `PCSrc` timing or value.

## Interface
Parameters:
- `CNT_WIDTH`, default 16: width of each statistics counter.

Ports (clock and reset first):
- `clk`  input  1  system clock; statistics logic only, rising-edge triggered.
- `rst`  input  1  asynchronous, active-high reset; clears statistics state only.
- `membranch`  input  1  branch control bit from the EX/MEM pipeline register.
- `zero`  input  1  ALU zero flag from the EX/MEM pipeline register.
- `clr_stats`  input  1  synchronous clear of the statistics counters and sticky flag.
- `PCSrc`  output  1  branch-taken select to the PC mux; purely combinational.
- `pcsrc_q`  output  1  `PCSrc` registered on `clk`.
- `branch_cnt`  output  CNT_WIDTH  number of cycles with `membranch`=1, saturating.
- `taken_cnt`  output  CNT_WIDTH  number of cycles with `PCSrc`=1, saturating.
- `taken_seen`  output  1  sticky flag; set once `PCSrc` has been 1 at any sampled edge.

## Operation
- `PCSrc` = `membranch` AND `zero`. Truth table rows:
  - 0,0 -> 0
  - 1,0 -> 0
  - 0,1 -> 0
  - 1,1 -> 1
- `PCSrc` has no dependence on `clk`, `rst`, `clr_stats` or any stored state.
- `PCSrc` must be correct even when `clk` and `rst` are undriven (X/Z).
- Statistics update on each rising `clk` edge while `rst`=0, in priority order:
  - `clr_stats`=1: `branch_cnt`, `taken_cnt` and `taken_seen` go to 0. `pcsrc_q` still loads `PCSrc`.
  - Otherwise:
    - `pcsrc_q` <= `PCSrc`.
    - `branch_cnt` increments if `membranch`=1.
    - `taken_cnt` increments if `PCSrc`=1.
    - `taken_seen` <= `taken_seen` | `PCSrc`.
- Saturation: a counter at all-ones holds its value and does not wrap.
- Invariant: `taken_cnt` <= `branch_cnt` at all times.
- X on an input propagates to `PCSrc` per standard AND semantics:
  - 0 AND X = 0.
  - 1 AND X = X.

## Timing
- `PCSrc`: zero-cycle combinational path. It settles within the same simulation timestep as its inputs, with no registers.
- Reset: `rst`=1 immediately, without a clock, forces:
  - `pcsrc_q` = 0
  - `branch_cnt` = 0
  - `taken_cnt` = 0
  - `taken_seen` = 0
- Statistics outputs hold those values while `rst`=1. `PCSrc` keeps following its inputs during reset.
- Reset deassertion: the first edge after `rst` falls performs a normal update.
- Reset asserted mid-count: counters clear at once. Nothing is retained.
- Statistics outputs have 1-cycle latency: the value reflects inputs sampled at the preceding rising edge.
- `clr_stats` and an increment in the same cycle: the clear wins, and the counters read 0 after the edge.

## Test plan
- Combinational truth table, no clock or reset driven. Apply (membranch, zero) = (0,0), (1,0), (0,1), (1,1), 1 ns apart -> `PCSrc` = 0, 0, 0, 1, each valid within its own timestep.
- Async reset: counters nonzero, assert `rst` between clock edges -> all four statistics outputs read 0 immediately. `PCSrc` unaffected.
- Counting: 10 cycles with `membranch`=1, of which `zero`=1 on 4 -> `branch_cnt`=10, `taken_cnt`=4, `taken_seen`=1, and `pcsrc_q` lags `PCSrc` by one cycle.
- Saturation with `CNT_WIDTH`=4: 20 cycles of (1,1) -> both counters stick at 15 without wrapping.
- `clr_stats` pulsed while (1,1) is applied -> counters read 0 after that edge and 1 after the next edge. `taken_seen` reads 0, then 1.
- X handling: `membranch`=0, `zero`=X -> `PCSrc`=0.
